// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pkg : shared types and constants for the instruction-fetch front end
// Rev 1.0
// ============================================================================
package ifetch_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_WORDS = 2048;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// ifetch_fifo : 2-entry fetch queue with registered head, flush and count
// Rev 1.0
// ============================================================================
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail;

  // Head keeps its last value when the queue empties so the outputs hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head  <= wdata;
            count <= 2'd1;
          end else begin
            tail  <= wdata;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= wdata;
          end else begin
            head <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// ifetch_unit : PC owner, instruction-memory fetch and decode-side queue
// Rev 1.0
// ============================================================================
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  output logic        im_r,
  input  logic [31:0] im_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_t       state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         fault_nxt;
  logic [1:0]   code_nxt;
  logic [1:0]   count;
  logic         legal, pop, issue;
  fetch_entry_t head;

  assign legal = {2'b00, pc[31:2]} < IMEM_LIMIT;
  assign pop   = out_valid & out_ready;
  // rst_n gates issue so the read enable is quiet throughout reset.
  assign issue = rst_n & (state == RUN) & ~redirect_valid
               & ((count != 2'd2) | pop) & legal;

  assign im_r      = issue;
  assign im_addr   = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault;
    code_nxt  = fault_code;
    if (redirect_valid) begin
      pc_nxt = {redirect_pc[31:2], 2'b00};
      if ((state == RUN) && (redirect_pc[1:0] != 2'b00)) begin
        state_nxt = HALT;
        fault_nxt = 1'b1;
        code_nxt  = FAULT_MISALIGN;
      end
    end else if ((state == RUN) && !legal) begin
      state_nxt = HALT;
      fault_nxt = 1'b1;
      code_nxt  = FAULT_RANGE;
    end else if (issue) begin
      pc_nxt = pc + 32'd4;
    end
  end

  ifetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ('{pc: pc, instr: im_rd}),
    .head  (head),
    .count (count)
  );

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch front end that drives the instruction-memory read port: address on im_addr, read enable on im_r, word returned combinationally on im_rd in the same cycle. It owns the PC, issues one word-aligned fetch per cycle while buffer space exists, and captures {pc, instr} pairs into a 2-entry queue. Decode pops the queue through a valid/ready handshake. Later stages redirect the unit (branch/jump/exception) via a single-cycle redirect strobe.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
IMEM_WORDS, 2048, instruction memory depth in 32-bit words; legal fetch iff pc[31:2] < IMEM_WORDS

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
im_addr  out  32  byte address to instruction memory; always equals pc, never X
im_r  out  1  instruction-memory read enable; high only in a cycle that pushes into the queue
im_rd  in  32  instruction word, valid combinationally in the same cycle im_r=1
redirect_valid  in  1  one-cycle strobe: flush queue and restart at redirect_pc
redirect_pc  in  32  new fetch address
out_valid  out  1  queue head valid
out_instr  out  32  queue head instruction
out_pc  out  32  byte address of queue head
out_ready  in  1  decode accepts head when out_valid and out_ready are both 1
fault  out  1  sticky; unit halted on an illegal fetch address
fault_code  out  2  0 none, 1 misaligned redirect, 2 out-of-range fetch

Behaviour:
- Reset is synchronous active-low on clk, as fixed above. While rst_n=0: pc=RESET_PC, queue count=0, out_valid=0, out_instr=0, out_pc=0, im_r=0, fault=0, fault_code=0, state=RUN.
- States: RUN and HALT. HALT is left only by reset.
- pop = out_valid & out_ready.
- issue = (state==RUN) & ~redirect_valid & (count<2 | pop) & legal(pc).
- im_r = issue. im_addr = pc in every cycle.
- On issue: push {pc, im_rd}, then pc <= pc+4. The add is mod 2^32, but the range check halts before any wrap.
- Queue: 2-entry FIFO, head presented registered. A word fetched in cycle N appears on out_* in cycle N+1 (1-cycle latency).
- Throughput: with out_ready held at 1, the unit sustains 1 instruction/cycle. Push and pop in the same cycle with count==2 leave count at 2. Push and pop with count==1 leave count at 1 and show the new word.
- Full: count==2 & ~pop -> im_r=0 and pc holds.
- Empty: out_valid=0. out_instr/out_pc hold their last values.
- Redirect (highest priority):
  - A pop in the same cycle still counts as a completed transfer.
  - All other entries are flushed, so count=0 next cycle and out_valid=0 next cycle.
  - No fetch is issued that cycle.
  - If redirect_pc[1:0]==0: pc <= redirect_pc.
  - Else: state <= HALT, fault <= 1, fault_code <= 1, pc <= redirect_pc with bits [1:0] cleared.
- Out-of-range: state==RUN, ~redirect_valid, and pc[31:2] >= IMEM_WORDS -> no issue, state <= HALT, fault <= 1, fault_code <= 2, pc holds.
- HALT: im_r=0. Queue entries already present still drain normally. A redirect in HALT still flushes the queue but does not restart fetch or change fault_code.
- Reset mid-operation: asserting rst_n=0 in any cycle discards the queue and returns all outputs to the reset values on that edge.

Decomposition:
- Package ifetch_pkg:
  - state enum {RUN, HALT}
  - fault code constants FAULT_NONE=0, FAULT_MISALIGN=1, FAULT_RANGE=2
  - default RESET_PC and IMEM_WORDS constants
  - a 64-bit fetch-entry struct {pc, instr}
- Sub-module: ifetch_fifo, a 2-entry synchronous FIFO with push/pop/flush, count, and a registered head. The same clk and rst_n rules apply to it.

Test Plan:
- Reset release, out_ready=1, imem word i = 32'h1000_0000+i -> im_r=1 from cycle 0, and from cycle 1 one word per cycle: (out_pc, out_instr) = (0, 32'h10000000), then (4, 32'h10000001), (8, 32'h10000002), ...
- out_ready=0 for 5 cycles after reset -> exactly 2 fetches issued (pc 0, 4), im_r=0 afterwards, pc=8. Then out_ready=1 -> heads 0, 4, 8 in consecutive cycles with no bubble.
- redirect_valid with redirect_pc=32'h100 while count=2 and pop=1 -> head 0 consumed, next cycle out_valid=0, the cycle after that out_pc=32'h100, then 32'h104.
- redirect_pc=32'h102 -> fault=1, fault_code=1, im_r stays 0 forever. A later redirect to 32'h200 does not restart fetch. Reset clears fault.
- IMEM_WORDS=4 with continuous fetch -> pcs 0..12 delivered, then fault_code=2, im_r=0, and queued words drain.
- rst_n=0 for one cycle while count=2 -> next cycle out_valid=0 and pc=RESET_PC, and fetch restarts at RESET_PC.
